// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and helpers for the load/store unit.
// Access-count and load-extension rules live here so the FSM stays small.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [2:0] n;
    logic       byte_mode;
  } lsu_count_t;

  function automatic lsu_count_t lsu_access_count(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo);
    lsu_count_t c;
    c.n         = 3'd1;
    c.byte_mode = 1'b1;
    case (funct3)
      F3_W: begin
        if (addr_lo == 2'b00) begin
          c.n         = 3'd1;
          c.byte_mode = 1'b0;
        end else begin
          c.n         = 3'd4;
          c.byte_mode = 1'b1;
        end
      end
      F3_H, F3_HU: c.n = 3'd2;
      default:     c.n = 3'd1;
    endcase
    return c;
  endfunction

  function automatic logic lsu_is_illegal(input logic [2:0] funct3, input logic we);
    logic bad;
    case (funct3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = funct3[2] & we;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] funct3, input logic [31:0] raw);
    logic [31:0] r;
    case (funct3)
      F3_B:    r = {{24{raw[7]}}, raw[7:0]};
      F3_H:    r = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   r = {24'h000000, raw[7:0]};
      F3_HU:   r = {16'h0000, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store initiator: one request per handshake, halfword and misaligned words
// are split into byte-wide memory cycles; loads are assembled then extended.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [1:0]            r_idx;
  logic [1:0]            r_last;
  logic                  r_byte_mode;
  logic                  r_err;

  logic                  w_hs;
  logic                  w_illegal;
  lsu_count_t            w_cnt;
  logic [1:0]            w_last;
  logic [4:0]            w_lane_lsb;

  assign w_hs       = req_valid_i & req_ready_o;
  assign w_illegal  = lsu_is_illegal(req_funct3_i, req_we_i);
  assign w_cnt      = lsu_access_count(req_funct3_i, req_addr_i[1:0]);
  // N=4 wraps to index 3, so the last index is always N-1 in two bits.
  assign w_last     = 2'(w_cnt.n - 3'd1);
  assign w_lane_lsb = {r_idx, 3'b000};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = w_illegal ? ST_RESP : ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_idx == r_last) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, byte index and load-data accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_acc       <= '0;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_byte_mode <= 1'b0;
      r_err       <= 1'b0;
    end else if (r_state == ST_IDLE && w_hs) begin
      r_we        <= req_we_i;
      r_funct3    <= req_funct3_i;
      r_addr      <= req_addr_i;
      r_wdata     <= req_wdata_i;
      r_acc       <= '0;
      r_idx       <= 2'd0;
      r_last      <= w_last;
      r_byte_mode <= w_cnt.byte_mode;
      r_err       <= w_illegal;
    end else if (r_state == ST_ACCESS) begin
      r_idx <= r_idx + 2'd1;
      if (!r_we) begin
        if (r_byte_mode) begin
          r_acc[w_lane_lsb +: BYTE_WIDTH] <= mem_rd_i[BYTE_WIDTH-1:0];
        end else begin
          r_acc <= mem_rd_i;
        end
      end
    end
  end

  // Memory port and response outputs, decoded from registered state.
  always_comb begin
    req_ready_o   = (r_state == ST_IDLE);
    mem_we_o      = 1'b0;
    mem_byte_op_o = 1'b0;
    mem_addr_o    = '0;
    mem_wd_o      = '0;
    resp_valid_o  = 1'b0;
    resp_err_o    = 1'b0;
    resp_rdata_o  = '0;
    if (r_state == ST_ACCESS) begin
      mem_we_o = r_we;
      if (r_byte_mode) begin
        mem_byte_op_o = 1'b1;
        mem_addr_o    = r_addr + DATA_WIDTH'(r_idx);
        mem_wd_o      = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, r_wdata[w_lane_lsb +: BYTE_WIDTH]};
      end else begin
        mem_addr_o = r_addr;
        mem_wd_o   = r_wdata;
      end
    end else if (r_state == ST_RESP) begin
      resp_valid_o = 1'b1;
      resp_err_o   = r_err;
      if (r_err || r_we) begin
        resp_rdata_o = '0;
      end else begin
        resp_rdata_o = lsu_extend(r_funct3, r_acc);
      end
    end else begin
      req_ready_o = (r_state == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic checked
// against a byte-array reference memory and plain-arithmetic load/latency rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  load_store_unit #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_we_o(mem_we_o), .mem_byte_op_o(mem_byte_op_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk = ~clk;

  wire        in_rng = (mem_addr_o[31:16] == 16'h0001);
  wire [15:0] ma     = mem_addr_o[15:0];

  assign mem_rd_i = !in_rng ? 32'h0 :
                    mem_byte_op_o ? {24'h0, mem[ma]} :
                    {mem[{ma[15:2], 2'd3}], mem[{ma[15:2], 2'd2}], mem[{ma[15:2], 2'd1}], mem[{ma[15:2], 2'd0}]};

  always @(negedge clk) begin
    if (mem_we_o && in_rng) begin
      if (mem_byte_op_o) begin
        mem[ma] <= mem_wd_o[7:0];
      end else begin
        mem[{ma[15:2], 2'd0}] <= mem_wd_o[7:0];
        mem[{ma[15:2], 2'd1}] <= mem_wd_o[15:8];
        mem[{ma[15:2], 2'd2}] <= mem_wd_o[23:16];
        mem[{ma[15:2], 2'd3}] <= mem_wd_o[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (f3[2] && we);
  endfunction

  function automatic int ref_latency(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (ref_illegal(we, f3)) return 1;
    n = ref_size(f3);
    if (n == 4 && a[1:0] == 2'd0) n = 1;
    return n + 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int size;
    logic [31:0] v, a_i;
    size = ref_size(f3);
    v = 32'h0;
    for (int i = 0; i < size; i++) begin
      a_i = a + 32'(i);
      v = v | (32'(ref_mem[a_i[15:0]]) << (8 * i));
    end
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] a_i;
    for (int i = 0; i < ref_size(f3); i++) begin
      a_i = a + 32'(i);
      ref_mem[a_i[15:0]] = wd[8*i +: 8];
    end
  endtask

  function automatic int mem_diffs(input logic [31:0] a, input int size);
    int d;
    logic [31:0] a_i;
    d = 0;
    for (int i = 0; i < size; i++) begin
      a_i = a + 32'(i);
      if (mem[a_i[15:0]] !== ref_mem[a_i[15:0]]) d++;
    end
    return d;
  endfunction

  // Drives one request and observes the transaction until the response pulse.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output int n_wr, output int n_byte,
                         output int n_word, output int rdy_hi);
    lat = -1; rdata = 32'hx; err = 1'bx; n_wr = 0; n_byte = 0; n_word = 0; rdy_hi = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready_o; k++) @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (req_ready_o) rdy_hi++;
      if (mem_we_o) n_wr++;
      if (mem_byte_op_o) n_byte++;
      else if (mem_addr_o != 32'h0) n_word++;
      if (resp_valid_o) begin
        lat = c; rdata = resp_rdata_o; err = resp_err_o;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    #12;
    n_checks++;
    if ({req_ready_o, resp_valid_o, resp_err_o, mem_we_o, mem_byte_op_o} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got ready/valid/err/we/byte=%b want 10000",
               {req_ready_o, resp_valid_o, resp_err_o, mem_we_o, mem_byte_op_o});
    end
    n_checks++;
    if ({resp_rdata_o, mem_addr_o, mem_wd_o} !== 96'h0) begin
      n_errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wd=%h want all 0", resp_rdata_o, mem_addr_o, mem_wd_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_word();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b010, 32'h10000, 32'hDEADBEEF, lat, rd, er, nw, nb, nwd, rh);
    ref_store(3'b010, 32'h10000, 32'hDEADBEEF);
    n_checks++;
    if (lat !== 2 || nw !== 1 || nb !== 0) begin
      n_errors++; $display("FAIL sw_word: lat=%0d writes=%0d bytecyc=%0d want 2/1/0", lat, nw, nb);
    end
    n_checks++;
    if (mem_diffs(32'h10000, 4) !== 0) begin
      n_errors++; $display("FAIL sw_word_mem: got %h want deadbeef", {mem[3], mem[2], mem[1], mem[0]});
    end
    run_req(1'b0, 3'b010, 32'h10000, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || nb !== 0 || nwd !== 1) begin
      n_errors++;
      $display("FAIL lw_word: lat=%0d rdata=%h err=%b byte=%0d word=%0d want 2/deadbeef/0/0/1", lat, rd, er, nb, nwd);
    end
  endtask

  task automatic test_byte();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b0, 3'b000, 32'h10003, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 2 || rd !== 32'hFFFFFFDE || nb !== 1) begin
      n_errors++; $display("FAIL lb: lat=%0d rdata=%h bytecyc=%0d want 2/ffffffde/1", lat, rd, nb);
    end
    run_req(1'b0, 3'b100, 32'h10003, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 2 || rd !== 32'h000000DE || nb !== 1) begin
      n_errors++; $display("FAIL lbu: lat=%0d rdata=%h bytecyc=%0d want 2/000000de/1", lat, rd, nb);
    end
  endtask

  task automatic test_half();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b001, 32'h10005, 32'h00008001, lat, rd, er, nw, nb, nwd, rh);
    ref_store(3'b001, 32'h10005, 32'h00008001);
    n_checks++;
    if (lat !== 3 || nw !== 2 || mem[16'h0005] !== 8'h01 || mem[16'h0006] !== 8'h80) begin
      n_errors++;
      $display("FAIL sh: lat=%0d writes=%0d m5=%h m6=%h want 3/2/01/80", lat, nw, mem[16'h0005], mem[16'h0006]);
    end
    run_req(1'b0, 3'b001, 32'h10005, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 3 || rd !== 32'hFFFF8001) begin
      n_errors++; $display("FAIL lh: lat=%0d rdata=%h want 3/ffff8001", lat, rd);
    end
    run_req(1'b0, 3'b101, 32'h10005, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 3 || rd !== 32'h00008001) begin
      n_errors++; $display("FAIL lhu: lat=%0d rdata=%h want 3/00008001", lat, rd);
    end
  endtask

  task automatic test_misaligned();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b010, 32'h10011, 32'h11223344, lat, rd, er, nw, nb, nwd, rh);
    ref_store(3'b010, 32'h10011, 32'h11223344);
    n_checks++;
    if (lat !== 5 || nw !== 4 || nb !== 4 || rh !== 0) begin
      n_errors++; $display("FAIL sw_mis: lat=%0d writes=%0d bytecyc=%0d ready_hi=%0d want 5/4/4/0", lat, nw, nb, rh);
    end
    n_checks++;
    if ({mem[16'h0014], mem[16'h0013], mem[16'h0012], mem[16'h0011]} !== 32'h11223344) begin
      n_errors++;
      $display("FAIL sw_mis_mem: got %h want 11223344", {mem[16'h0014], mem[16'h0013], mem[16'h0012], mem[16'h0011]});
    end
    run_req(1'b0, 3'b010, 32'h10011, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 5 || rd !== 32'h11223344 || rh !== 0) begin
      n_errors++; $display("FAIL lw_mis: lat=%0d rdata=%h ready_hi=%0d want 5/11223344/0", lat, rd, rh);
    end
  endtask

  task automatic test_illegal();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b0, 3'b011, 32'h10000, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nw !== 0 || nb !== 0 || nwd !== 0) begin
      n_errors++; $display("FAIL illegal_011: lat=%0d err=%b rdata=%h writes=%0d want 1/1/0/0", lat, er, rd, nw);
    end
    run_req(1'b1, 3'b100, 32'h10008, 32'h000000AA, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nw !== 0 || mem[16'h0008] !== 8'h00) begin
      n_errors++; $display("FAIL illegal_sbu: lat=%0d err=%b rdata=%h writes=%0d want 1/1/0/0", lat, er, rd, nw);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    run_req(1'b0, 3'b010, 32'h10000, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL b2b_ready: ready=%b valid=%b want 1/0", req_ready_o, resp_valid_o);
    end
    run_req(1'b0, 3'b001, 32'h10000, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 3 || rd !== ref_load(3'b001, 32'h10000)) begin
      n_errors++; $display("FAIL b2b_lh: lat=%0d rdata=%h want 3/%h", lat, rd, ref_load(3'b001, 32'h10000));
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, nw, nb, nwd, rh; logic [31:0] rd; logic er;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
    req_addr_i = 32'h10021; req_wdata_i = 32'h11223344;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h10023) begin
      n_errors++; $display("FAIL rst_pre: we=%b addr=%h want 1/00010023", mem_we_o, mem_addr_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({mem_we_o, mem_byte_op_o, req_ready_o, resp_valid_o, resp_err_o} !== 5'b00100 ||
        {mem_addr_o, mem_wd_o, resp_rdata_o} !== 96'h0) begin
      n_errors++;
      $display("FAIL rst_async: we=%b byte=%b ready=%b valid=%b addr=%h want 0/0/1/0/0",
               mem_we_o, mem_byte_op_o, req_ready_o, resp_valid_o, mem_addr_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    ref_mem[16'h0021] = 8'h44;
    ref_mem[16'h0022] = 8'h33;
    n_checks++;
    if (mem_diffs(32'h10021, 4) !== 0) begin
      n_errors++;
      $display("FAIL rst_mem: got %h %h %h want 44 33 00", mem[16'h0021], mem[16'h0022], mem[16'h0023]);
    end
    run_req(1'b0, 3'b010, 32'h10000, 32'h0, lat, rd, er, nw, nb, nwd, rh);
    n_checks++;
    if (lat !== 2 || rd !== ref_load(3'b010, 32'h10000) || er !== 1'b0) begin
      n_errors++; $display("FAIL rst_after_lw: lat=%0d rdata=%h want 2/%h", lat, rd, ref_load(3'b010, 32'h10000));
    end
  endtask

  task automatic test_random();
    int lat, nw, nb, nwd, rh, exp_lat; logic [31:0] rd, a, wd, exp_rd; logic er, we, ill;
    logic [2:0] f3;
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h10000 + 32'($urandom_range(0, 255));
      wd = $urandom;
      ill = ref_illegal(we, f3);
      exp_lat = ref_latency(we, f3, a);
      exp_rd = (ill || we) ? 32'h0 : ref_load(f3, a);
      run_req(we, f3, a, wd, lat, rd, er, nw, nb, nwd, rh);
      if (we && !ill) ref_store(f3, a, wd);
      n_checks++;
      if (lat !== exp_lat || rd !== exp_rd || er !== ill) begin
        n_errors++;
        $display("FAIL rand_%0d we=%b f3=%b a=%h: lat=%0d rdata=%h err=%b want %0d/%h/%b",
                 it, we, f3, a, lat, rd, er, exp_lat, exp_rd, ill);
      end
      if (we) begin
        n_checks++;
        if (mem_diffs(a, 4) !== 0) begin
          n_errors++; $display("FAIL rand_mem_%0d a=%h: %0d bytes differ from 0", it, a, mem_diffs(a, 4));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the core's execute stage and `data_memory`. It accepts one load or store per handshake with a RISC-V width code (funct3). It drives the memory's word/byte port and splits halfword and misaligned-word accesses into byte-wide memory cycles. It assembles and extends load data and returns a single-cycle response.

## Interface

- `DATA_WIDTH`, 32, data/address width
- `BYTE_WIDTH`, 8, width of one memory byte lane
- `clk_i`  in  1  clock; all flops rise-edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  unit can accept a request
- `req_we_i`  in  1  1 = store, 0 = load
- `req_funct3_i`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr_i`  in  DATA_WIDTH  byte address
- `req_wdata_i`  in  DATA_WIDTH  store data, LSB-aligned
- `resp_valid_o`  out  1  one-cycle completion pulse
- `resp_rdata_o`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `resp_err_o`  out  1  illegal funct3, valid with `resp_valid_o`
- `mem_we_o`  out  1  memory write enable
- `mem_byte_op_o`  out  1  1 = byte access, 0 = aligned word
- `mem_addr_o`  out  DATA_WIDTH  memory address
- `mem_wd_o`  out  DATA_WIDTH  memory write data
- `mem_rd_i`  in  DATA_WIDTH  memory read data, combinational from `mem_addr_o` and `mem_byte_op_o`

## Operation

- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready_o`=1.
  - A handshake (`req_valid_i & req_ready_o`) latches we, funct3, addr and wdata.
  - It also loads the access count N:
    - Word with addr[1:0]=0: N=1, word mode.
    - Byte or BU: N=1, byte mode.
    - Half or HU: N=2, byte mode, at any alignment.
    - Word with addr[1:0]≠0: N=4, byte mode.
  - Illegal codes are 011, 110 and 111, plus funct3[2]=1 with we=1. An illegal request goes straight to RESP with `resp_err_o`=1 and makes no memory cycle.
  - A legal request goes to ACCESS with idx=0.
- ACCESS (one memory cycle per clock; mem outputs are combinational from registered state):
  - Word mode: `mem_addr_o`=addr, `mem_byte_op_o`=0, `mem_wd_o`=wdata.
  - Byte mode: `mem_addr_o`=addr+idx (modulo 2^32), `mem_byte_op_o`=1, `mem_wd_o`={zeros, wdata byte lane idx}.
  - `mem_we_o` equals the latched we for every ACCESS cycle.
  - Loads capture `mem_rd_i` on the rising edge: the full word in word mode, or byte [7:0] into accumulator lane idx.
  - idx increments each cycle. When idx=N-1 the next state is RESP.
- RESP:
  - `resp_valid_o`=1 for exactly one cycle, then IDLE.
  - `resp_rdata_o` extension: B sign-extends bit 7; H sign-extends bit 15; BU/HU zero-extend; W passes through.
- Outside ACCESS all `mem_*` outputs are 0. Outside RESP, `resp_valid_o`, `resp_rdata_o` and `resp_err_o` are 0.
- The accumulator clears on each handshake, so stale lanes never leak into a response.

## Timing

- Reset values: state IDLE, `req_ready_o`=1, `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, all `mem_*`=0.
- Reset is asynchronous:
  - Asserting `rst_ni` mid-ACCESS drops `mem_we_o` immediately.
  - Byte writes already completed stay in memory; no rollback.
  - The pending response is discarded.
- Latency, counted from the handshake edge (cycle 0):
  - N=1: `resp_valid_o` in cycle 2.
  - N=2: `resp_valid_o` in cycle 3.
  - N=4: `resp_valid_o` in cycle 5.
  - Illegal request: `resp_valid_o` in cycle 1.
- `req_ready_o` is low from cycle 1 through the RESP cycle. The next request can be accepted in the cycle after RESP.
- Memory writes land on the falling edge inside each ACCESS cycle, so a load in the next transaction sees them.

## Structure

- `lsu_pkg` holds:
  - state enum
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - function `lsu_access_count(funct3, addr_lo)` returning N and mode
  - function `lsu_extend(funct3, raw)`
- No sub-module; a single FSM with a 2-bit idx counter and a byte-lane accumulator.

## Test plan

The bench memory model has combinational read and negedge write, with 0x10000–0x1FFFF preloaded to 0.

- SW 0x10000 with data 0xDEADBEEF, then LW 0x10000 → one word-mode cycle each; LW `resp_rdata_o`=0xDEADBEEF in cycle 2.
- After the SW above, LB 0x10003 → 0xFFFFFFDE; LBU 0x10003 → 0x000000DE; both single byte-mode cycles.
- SH 0x10005 with data 0x00008001 → byte writes 0x01@0x10005, 0x80@0x10006. LH 0x10005 → 0xFFFF8001 in cycle 3. LHU → 0x00008001.
- SW 0x10011 with data 0x11223344 → byte writes 44, 33, 22, 11 at 0x10011–0x10014. LW 0x10011 → 0x11223344 in cycle 5. `req_ready_o` is low in cycles 1–5.
- funct3=011, and SB with funct3=100 → `mem_we_o` never asserted; `resp_err_o`=1 and `resp_rdata_o`=0 in cycle 1.
- Reset asserted during the 3rd byte of the misaligned SW:
  - `mem_we_o` goes to 0 asynchronously and all outputs take reset values.
  - Bytes 0x44 and 0x33 are present in memory.
  - A following LW 0x10000 completes normally.
